// File: rtl/bp_input_packer_pkg.sv
// Shared sizing helpers for the butterfly-processor input packer.
// Slice width and beats-per-vector are derived here so top and channels agree.
package bp_input_packer_pkg;

  function automatic int unsigned calc_slice_w(int unsigned elem_w, int unsigned par,
                                               int unsigned n_chnl);
    return (2 * elem_w * par) / n_chnl;
  endfunction

  function automatic int unsigned calc_beats(int unsigned slice_w, int unsigned axi_w);
    return slice_w / axi_w;
  endfunction

  // The vector must split evenly into channels, and each slice into whole AXI beats.
  function automatic bit sizes_ok(int unsigned axi_w, int unsigned n_chnl,
                                  int unsigned elem_w, int unsigned par);
    int unsigned slice_w;
    slice_w = calc_slice_w(elem_w, par, n_chnl);
    return (n_chnl != 0) && (axi_w != 0) && (((2 * elem_w * par) % n_chnl) == 0) &&
           (slice_w >= axi_w) && ((slice_w % axi_w) == 0);
  endfunction

endpackage

// File: rtl/bp_input_packer_chnl.sv
// One input channel: gathers Beats AXI beats into a slice, holds it for the
// processor, counts handed-off vectors per frame and checks TLAST placement.
module bp_input_packer_chnl #(
  parameter int unsigned DataW  = 256,
  parameter int unsigned SliceW = 512,
  parameter int unsigned Beats  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DataW-1:0]  s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  input  logic [15:0]       length,
  input  logic              clear_err,
  output logic [SliceW-1:0] up_dat,
  output logic              up_vld,
  input  logic              up_rdy,
  output logic              frame_done,
  output logic              err
);

  localparam int unsigned CntW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [SliceW-1:0] out_reg_q, out_reg_d, packed_vec;
  logic              out_vld_q, out_vld_d;
  logic [15:0]       vec_cnt_q, vec_cnt_d;
  logic [15:0]       load_cnt_q, load_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;

  logic        last_beat, accept, load, handoff, len_nz, exp_last;
  logic [15:0] len_m1;

  assign last_beat = (beat_cnt_q == LastCnt);
  // up_rdy feeds s_tready combinationally so a full channel streams without bubbles.
  assign s_tready  = !last_beat || !out_vld_q || up_rdy;
  assign accept    = s_tvalid && s_tready;
  assign load      = accept && last_beat;
  assign handoff   = out_vld_q && up_rdy;
  assign len_nz    = |length;
  assign len_m1    = length - 16'd1;
  // Load-side counter can lead the handoff counter by one held vector.
  assign exp_last  = last_beat && len_nz && (load_cnt_q == len_m1);

  if (Beats > 1) begin : g_acc
    logic [DataW-1:0] acc_q [Beats-1];
    logic [DataW-1:0] acc_d [Beats-1];

    always_comb begin
      acc_d = acc_q;
      for (int unsigned k = 0; k < Beats - 1; k++) begin
        if (accept && !last_beat && (beat_cnt_q == CntW'(k))) acc_d[k] = s_tdata;
      end
    end

    always_comb begin
      packed_vec = '0;
      for (int unsigned k = 0; k < Beats - 1; k++) begin
        packed_vec[k*DataW +: DataW] = acc_q[k];
      end
      packed_vec[SliceW-1 -: DataW] = s_tdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '{default: '0};
      else        acc_q <= acc_d;
    end
  end else begin : g_no_acc
    assign packed_vec = s_tdata;
  end

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    out_reg_d    = out_reg_q;
    out_vld_d    = out_vld_q;
    vec_cnt_d    = vec_cnt_q;
    load_cnt_d   = load_cnt_q;
    frame_done_d = 1'b0;
    err_d        = err_q;

    if (accept) beat_cnt_d = last_beat ? '0 : beat_cnt_q + CntW'(1);

    if (load) begin
      out_reg_d  = packed_vec;
      out_vld_d  = 1'b1;
      load_cnt_d = (len_nz && (load_cnt_q == len_m1)) ? 16'd0 : load_cnt_q + 16'd1;
    end else if (handoff) begin
      out_vld_d = 1'b0;
    end

    if (handoff) begin
      if (len_nz && (vec_cnt_q == len_m1)) begin
        vec_cnt_d    = 16'd0;
        frame_done_d = 1'b1;
      end else begin
        vec_cnt_d = vec_cnt_q + 16'd1;
      end
    end

    if (clear_err)                            err_d = 1'b0;
    else if (accept && (s_tlast != exp_last)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q   <= '0;
      out_reg_q    <= '0;
      out_vld_q    <= 1'b0;
      vec_cnt_q    <= 16'd0;
      load_cnt_q   <= 16'd0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      out_reg_q    <= out_reg_d;
      out_vld_q    <= out_vld_d;
      vec_cnt_q    <= vec_cnt_d;
      load_cnt_q   <= load_cnt_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign up_dat     = out_reg_q;
  assign up_vld     = out_vld_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: rtl/bp_input_packer.sv
// Butterfly-processor input packer: one packing channel per AXI-Stream input,
// slices concatenated into the processor vector under a shared up_rdy.
module bp_input_packer
  import bp_input_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_AXI = 256,
  parameter int unsigned INPUT_AXI_CHNL = 8,
  parameter int unsigned data_width     = 16,
  parameter int unsigned be_parallelism = 128
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [DATA_WIDTH_AXI*INPUT_AXI_CHNL-1:0] s_tdata,
  input  logic [INPUT_AXI_CHNL-1:0]                s_tvalid,
  input  logic [INPUT_AXI_CHNL-1:0]                s_tlast,
  output logic [INPUT_AXI_CHNL-1:0]                s_tready,
  input  logic [15:0]                              length,
  input  logic                                     clear_err,
  output logic [2*data_width*be_parallelism-1:0]   up_dat,
  output logic [INPUT_AXI_CHNL-1:0]                up_vld,
  input  logic                                     up_rdy,
  output logic [INPUT_AXI_CHNL-1:0]                frame_done,
  output logic [INPUT_AXI_CHNL-1:0]                err
);

  localparam int unsigned SLICE_W = calc_slice_w(data_width, be_parallelism, INPUT_AXI_CHNL);
  localparam int unsigned BEATS   = calc_beats(SLICE_W, DATA_WIDTH_AXI);

  if (!sizes_ok(DATA_WIDTH_AXI, INPUT_AXI_CHNL, data_width, be_parallelism)) begin : g_bad_size
    $error("bp_input_packer: slice width must be a whole multiple of DATA_WIDTH_AXI");
  end

  for (genvar c = 0; c < INPUT_AXI_CHNL; c++) begin : g_chnl
    bp_input_packer_chnl #(
      .DataW  (DATA_WIDTH_AXI),
      .SliceW (SLICE_W),
      .Beats  (BEATS)
    ) u_chnl (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_tdata    (s_tdata[c*DATA_WIDTH_AXI +: DATA_WIDTH_AXI]),
      .s_tvalid   (s_tvalid[c]),
      .s_tlast    (s_tlast[c]),
      .s_tready   (s_tready[c]),
      .length     (length),
      .clear_err  (clear_err),
      .up_dat     (up_dat[c*SLICE_W +: SLICE_W]),
      .up_vld     (up_vld[c]),
      .up_rdy     (up_rdy),
      .frame_done (frame_done[c]),
      .err        (err[c])
    );
  end

endmodule

// File: tb/tb_bp_input_packer.sv
// Directed bench for bp_input_packer with a per-channel scoreboard of packed
// slices, checked on every handoff.
module tb_bp_input_packer;

  localparam int unsigned AxiW   = 256;
  localparam int unsigned NCh    = 8;
  localparam int unsigned SliceW = 512;

  typedef logic [SliceW-1:0] slice_t;

  logic                 clk;
  logic                 rst_n;
  logic [AxiW*NCh-1:0]  s_tdata;
  logic [NCh-1:0]       s_tvalid;
  logic [NCh-1:0]       s_tlast;
  logic [NCh-1:0]       s_tready;
  logic [15:0]          length;
  logic                 clear_err;
  logic [SliceW*NCh-1:0] up_dat;
  logic [NCh-1:0]       up_vld;
  logic                 up_rdy;
  logic [NCh-1:0]       frame_done;
  logic [NCh-1:0]       err;

  bp_input_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .length     (length),
    .clear_err  (clear_err),
    .up_dat     (up_dat),
    .up_vld     (up_vld),
    .up_rdy     (up_rdy),
    .frame_done (frame_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int               mcnt  [NCh];
  bit               mvld  [NCh];
  logic [AxiW-1:0]  macc  [NCh];
  slice_t           sb    [NCh][$];
  int               nhand [NCh];
  int               nfd   [NCh];
  int               fd_at [NCh];

  task automatic check(string tag, slice_t obs, slice_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AxiW-1:0] rnd256();
    logic [AxiW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCh; c++) begin
      mcnt[c]  = 0;
      mvld[c]  = 1'b0;
      macc[c]  = '0;
      sb[c].delete();
      nhand[c] = 0;
      nfd[c]   = 0;
      fd_at[c] = -1;
    end
  endtask

  // One clock: check ready/valid against the model before the edge, then commit.
  task automatic cycle();
    bit              exp_rdy, ho, ld;
    logic [AxiW-1:0] beat;
    slice_t          exp;
    #1;
    for (int c = 0; c < NCh; c++) begin
      exp_rdy = (mcnt[c] != 1) || !mvld[c] || up_rdy;
      check($sformatf("tready[%0d]", c), slice_t'(s_tready[c]), slice_t'(exp_rdy));
      check($sformatf("up_vld[%0d]", c), slice_t'(up_vld[c]), slice_t'(mvld[c]));
      ho = mvld[c] && up_rdy;
      ld = 1'b0;
      if (ho) begin
        nhand[c]++;
        if (sb[c].size() == 0) begin
          check($sformatf("sb_empty[%0d]", c), slice_t'(1), slice_t'(0));
        end else begin
          exp = sb[c].pop_front();
          check($sformatf("up_dat[%0d]", c), up_dat[c*SliceW +: SliceW], exp);
        end
      end
      if (s_tvalid[c] && exp_rdy) begin
        beat = s_tdata[c*AxiW +: AxiW];
        if (mcnt[c] == 0) begin
          macc[c] = beat;
          mcnt[c] = 1;
        end else begin
          sb[c].push_back({beat, macc[c]});
          mcnt[c] = 0;
          ld = 1'b1;
        end
      end
      if (ld)      mvld[c] = 1'b1;
      else if (ho) mvld[c] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NCh; c++) begin
      if (frame_done[c]) begin
        nfd[c]++;
        fd_at[c] = nhand[c];
      end
    end
  endtask

  task automatic drive(int c, logic [AxiW-1:0] d, bit last);
    s_tvalid = '0;
    s_tlast  = '0;
    s_tvalid[c] = 1'b1;
    s_tlast[c]  = last;
    s_tdata[c*AxiW +: AxiW] = d;
    cycle();
  endtask

  task automatic idle(int n);
    s_tvalid = '0;
    s_tlast  = '0;
    repeat (n) cycle();
  endtask

  task automatic apply_reset();
    s_tvalid = '0;
    s_tlast  = '0;
    rst_n    = 1'b0;
    #1;
    check("rst_up_vld", slice_t'(up_vld), slice_t'(0));
    check("rst_up_dat", slice_t'(|up_dat), slice_t'(0));
    check("rst_frame_done", slice_t'(frame_done), slice_t'(0));
    check("rst_err", slice_t'(err), slice_t'(0));
    check("rst_tready", slice_t'(s_tready), slice_t'(8'hff));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  logic [AxiW-1:0] va, vb, vc, vd;

  initial begin
    rst_n     = 1'b0;
    s_tdata   = '0;
    s_tvalid  = '0;
    s_tlast   = '0;
    length    = 16'd0;
    clear_err = 1'b0;
    up_rdy    = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Single channel, two beats A then B.
    va = {32{8'hAA}};
    vb = {32{8'hBB}};
    drive(0, va, 1'b0);
    drive(0, vb, 1'b0);
    s_tvalid = '0;
    check("t1_up_vld", slice_t'(up_vld), slice_t'(8'h01));
    check("t1_up_dat", up_dat[SliceW-1:0], {vb, va});
    idle(1);

    // All channels streaming back to back.
    for (int c = 0; c < NCh; c++) nhand[c] = 0;
    for (int i = 0; i < 64; i++) begin
      s_tvalid = '1;
      for (int c = 0; c < NCh; c++) s_tdata[c*AxiW +: AxiW] = rnd256();
      cycle();
    end
    idle(2);
    for (int c = 0; c < NCh; c++) check($sformatf("t2_hand[%0d]", c), slice_t'(nhand[c]),
                                        slice_t'(32));

    // Backpressure on channel 3.
    for (int c = 0; c < NCh; c++) nhand[c] = 0;
    up_rdy = 1'b0;
    va = rnd256(); vb = rnd256(); vc = rnd256(); vd = rnd256();
    drive(3, va, 1'b0);
    drive(3, vb, 1'b0);
    drive(3, vc, 1'b0);
    s_tvalid = '0;
    s_tvalid[3] = 1'b1;
    s_tdata[3*AxiW +: AxiW] = vd;
    #1;
    check("t3_tready_low", slice_t'(s_tready[3]), slice_t'(0));
    cycle();
    cycle();
    up_rdy = 1'b1;
    cycle();
    s_tvalid = '0;
    check("t3_vld_held", slice_t'(up_vld[3]), slice_t'(1));
    check("t3_dat2", up_dat[3*SliceW +: SliceW], {vd, vc});
    idle(1);
    check("t3_hand", slice_t'(nhand[3]), slice_t'(2));

    // Framing with length 4: tlast on the 8th beat, then misplaced on the 6th.
    apply_reset();
    length = 16'd4;
    for (int i = 0; i < 8; i++) drive(0, rnd256(), i == 7);
    idle(2);
    check("t4_fd_count", slice_t'(nfd[0]), slice_t'(1));
    check("t4_fd_at", slice_t'(fd_at[0]), slice_t'(4));
    check("t4_err_ok", slice_t'(err), slice_t'(0));
    for (int i = 0; i < 8; i++) drive(0, rnd256(), i == 5);
    idle(2);
    check("t4_err_set", slice_t'(err), slice_t'(8'h01));
    check("t4_fd_count2", slice_t'(nfd[0]), slice_t'(2));
    idle(2);
    check("t4_err_sticky", slice_t'(err), slice_t'(8'h01));
    clear_err = 1'b1;
    cycle();
    clear_err = 1'b0;
    check("t4_err_clr", slice_t'(err), slice_t'(0));

    // length 0: counter free-runs, no frame pulses.
    apply_reset();
    length = 16'd0;
    for (int i = 0; i < 40; i++) drive(0, rnd256(), 1'b0);
    idle(2);
    check("t5_fd_none", slice_t'(nfd[0]), slice_t'(0));
    check("t5_hand", slice_t'(nhand[0]), slice_t'(20));
    check("t5_err", slice_t'(err), slice_t'(0));

    // Reset in the middle of a vector discards the partial beat.
    drive(0, {32{8'h5A}}, 1'b0);
    apply_reset();
    va = {32{8'h11}};
    vb = {32{8'h22}};
    drive(0, va, 1'b0);
    drive(0, vb, 1'b0);
    s_tvalid = '0;
    check("t6_up_vld", slice_t'(up_vld), slice_t'(8'h01));
    check("t6_up_dat", up_dat[SliceW-1:0], {vb, va});
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_input_packer.md
Name: bp_input_packer

Overview:
Upstream feeder of the butterfly processor. It takes INPUT_AXI_CHNL independent AXI-Stream input channels, each DATA_WIDTH_AXI bits wide. For each channel it gathers BEATS consecutive beats into one per-channel slice of the processor's real+complex up_dat vector, and presents that slice with its own per-channel up_vld under the processor's single shared up_rdy. It also counts vectors per frame against `length` and flags TLAST framing errors.

Parameters:
DATA_WIDTH_AXI, 256, width of one AXI input beat per channel
INPUT_AXI_CHNL, 8, number of AXI input channels; each feeds one up_vld bit
data_width, 16, width of one real or complex element
be_parallelism, 128, number of elements in the processor vector
Derived localparam SLICE_W = 2*data_width*be_parallelism/INPUT_AXI_CHNL (default 512)
Derived localparam BEATS = SLICE_W/DATA_WIDTH_AXI (default 2); must be an integer ≥ 1, checked at elaboration

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_tdata  in  DATA_WIDTH_AXI*INPUT_AXI_CHNL  channel c occupies bits [c*DATA_WIDTH_AXI +: DATA_WIDTH_AXI]
s_tvalid  in  INPUT_AXI_CHNL  per-channel beat valid
s_tlast  in  INPUT_AXI_CHNL  per-channel end-of-frame marker
s_tready  out  INPUT_AXI_CHNL  per-channel beat ready
length  in  16  vectors per frame; quasi-static, sampled on every vector handoff
clear_err  in  1  synchronous clear of err
up_dat  out  2*data_width*be_parallelism  channel c slice at [c*SLICE_W +: SLICE_W]
up_vld  out  INPUT_AXI_CHNL  per-channel slice valid
up_rdy  in  1  shared ready from processor
frame_done  out  INPUT_AXI_CHNL  one-cycle pulse when a channel hands off the last vector of a frame
err  out  INPUT_AXI_CHNL  sticky TLAST framing error per channel

Behaviour:
- Reset is asynchronous on rst_n: clk and rst_n exactly as decided. All of the following clear to 0: beat_cnt, vec_cnt, accumulators, output regs, up_vld, frame_done, err. s_tready is 1 out of reset.
- Channels are fully independent except for the shared up_rdy.
- Per-channel state:
  - beat_cnt, range 0..BEATS-1
  - acc: (BEATS-1) beats
  - out_reg: SLICE_W bits, with out_vld
  - vec_cnt: 16 bits
- Beat accept (tvalid && tready):
  - If beat_cnt < BEATS-1: store the beat in acc[beat_cnt], then beat_cnt++.
  - If beat_cnt == BEATS-1: load out_reg = {beat, acc[BEATS-2..0]}, so beat k lands at slice bits [k*DATA_WIDTH_AXI +: DATA_WIDTH_AXI]. Set out_vld and reset beat_cnt to 0.
- s_tready[c] = (beat_cnt != BEATS-1) || !out_vld || up_rdy. This combinational up_rdy→s_tready path is intentional: it sustains one beat per cycle with zero bubbles.
- up_vld[c] = out_vld. A handoff happens when out_vld && up_rdy.
- Handoff and a final-beat load in the same cycle: out_reg takes the new vector and out_vld stays 1.
- Handoff with no new load: out_vld goes to 0.
- Latency: the slice is valid on up_vld the cycle after the final beat is accepted.
- Frame counting:
  - Each handoff increments vec_cnt.
  - When vec_cnt == length-1 at handoff: vec_cnt wraps to 0 and frame_done pulses for 1 cycle, registered.
  - length == 0: vec_cnt free-runs modulo 2^16 and frame_done never fires.
- TLAST check on an accepted beat:
  - Expected tlast = (final beat of vector) && (vec_cnt_at_load == length-1). vec_cnt_at_load counts completed loads and runs one vector ahead of or equal to the handoff count; err uses the load-side counter, which is kept separately.
  - Mismatch sets err[c]. err is sticky; data flow is unaffected.
  - clear_err has priority over a same-cycle set: err = 0.
- When s_tvalid is low, nothing changes.
- Reset asserted mid-vector: partial beats are discarded and beat_cnt returns to 0.
- BEATS == 1: the acc array is absent and every beat is a final beat.

Decomposition:
- Shared package: BEATS/SLICE_W derivation functions and the elaboration-time integer check.
- Natural sub-module: bp_input_packer_chnl (one channel's beat counter, acc, out_reg, vec counters, err). The top generates INPUT_AXI_CHNL instances and concatenates slices. up_rdy fans to all instances.

Test Plan:
- Ch0 only, beats 0xA..A then 0xB..B, up_rdy=1 → cycle after the 2nd beat: up_vld[0]=1, up_dat[511:0]={B..B,A..A}, and up_vld[7:1] stay 0.
- All 8 channels streaming back-to-back with up_rdy=1 for 64 beats → 32 handoffs per channel, s_tready constantly 1, no bubbles.
- up_rdy=0 while ch3 completes one vector and then sends 1 beat of the next → s_tready[3]=0 on the 2nd beat. Raising up_rdy → same-cycle handoff and load; the 2nd vector appears the next cycle with data intact.
- length=4, tlast on the 8th beat → frame_done[0] pulses once on the 4th handoff and err stays 0. Repeat with tlast on the 6th beat → err[0]=1 until clear_err.
- length=0, 20 vectors → frame_done never asserts and vec_cnt=20.
- rst_n asserted after 1 beat of a vector → all outputs 0 and s_tready=1. A fresh 2-beat vector then packs correctly with no stale beat.
